crc_mem_sched: RTL and testbench
================================

CRC_MEM_SCHED -- requirements
Module: crc_mem_sched

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 2: rewrites allowed per transfer after an uncorrected CRC error (range 0..7).
REQ-002 SHALL have parameter ERR_THRESH, default 4: cumulative detected-error count that forces FAULT (range 1..255).
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports req0_valid / req1_valid, input, 1: requester N has a write pending.
REQ-006 SHALL have ports req0_data / req1_data, input, 32: requester N write data.
REQ-007 SHALL have ports req0_ready / req1_ready, output, 1: one-cycle accept pulse to requester N.
REQ-008 SHALL have port mem1_wr, output, 1: write strobe to the CRC-protected 32-bit memory.
REQ-009 SHALL have port mem1_data_in, output, 32: write data to the memory.
REQ-010 SHALL have ports mem1_err_detected / mem1_err_corrected, input, 1: memory CRC status.
REQ-011 SHALL have port fault_clr, input, 1: software clear of FAULT.
REQ-012 SHALL have port fault, output, 1: sticky fault indication.
REQ-013 SHALL have port err_cnt, output, 8: saturating count of detected errors.

Function
REQ-014 SHALL implement FSM states IDLE, WRITE, CHECK, FAULT.
REQ-015 IDLE: if any reqN_valid, SHALL grant one requester, pulse its ready in that same cycle, latch its data, and go to WRITE; otherwise stay in IDLE.
REQ-016 Arbitration SHALL be two-way round-robin: when both requesters are valid, grant the one not granted last; a lone valid requester SHALL always win.
REQ-017 SHALL never assert both readys in one cycle; readys SHALL be 0 outside IDLE.
REQ-018 WRITE: SHALL assert mem1_wr=1 for exactly one cycle with mem1_data_in = latched data, then go to CHECK.
REQ-019 CHECK: SHALL sample status for one cycle; none or err_corrected=1 -> IDLE and reset the retry count.
REQ-020 CHECK with err_detected=1 and err_corrected=0: if the retry count < MAX_RETRY, SHALL increment it and go to WRITE, rewriting the same latched data; otherwise SHALL go to FAULT.
REQ-021 Every CHECK cycle with err_detected=1 SHALL increment err_cnt, saturating at 255.
REQ-022 If err_cnt reaches ERR_THRESH after an increment, SHALL go to FAULT regardless of the corrected or retry outcome.
REQ-023 fault SHALL equal 1 exactly while the state is FAULT.
REQ-024 FAULT: mem1_wr=0 and readys=0; on fault_clr=1, SHALL clear err_cnt and the retry count and go to IDLE next cycle.
REQ-025 fault_clr outside FAULT SHALL be ignored.
REQ-026 mem1_data_in SHALL hold its last value when mem1_wr=0.
REQ-027 Best-case throughput SHALL be one transfer per 3 cycles (IDLE→WRITE→CHECK).

Reset
REQ-028 On rst_n=0, mid-transfer included, SHALL immediately go to IDLE with mem1_wr=0, mem1_data_in=0, readys=0, fault=0, err_cnt=0, retry count=0, and the arbiter's last-grant set to req1, so req0 wins the first tie.
REQ-029 A transfer aborted by reset SHALL NOT be replayed.

Structure
REQ-030 Package crc_sched_pkg SHALL hold the state enum type and the MAX_RETRY/ERR_THRESH defaults.
REQ-031 The round-robin arbiter SHALL be a sub-module rr_arb2 (inputs: two valids, grant-enable; outputs: one-hot grant; internal last-grant flop).

Verification
REQ-032 Single write: req0_valid=1, data 0xDEADBEEF, no errors -> req0_ready pulse, mem1_wr 1 cycle later with 0xDEADBEEF, back in IDLE 3 cycles after accept, err_cnt=0.
REQ-033 Contention: both valid continuously for 4 grants after reset -> grant order req0, req1, req0, req1; never both readys high.
REQ-034 Corrected error: err_detected=1 and err_corrected=1 in CHECK -> no rewrite, err_cnt=1, next request accepted.
REQ-035 Retry exhaustion, MAX_RETRY=2: uncorrected error on every CHECK -> 3 mem1_wr pulses with identical data, then fault=1, err_cnt=3.
REQ-036 Threshold, ERR_THRESH=4: four transfers with corrected errors -> fault=1 after the 4th CHECK; fault_clr=1 -> fault=0, err_cnt=0, IDLE next cycle.
REQ-037 Reset mid-operation: rst_n low during WRITE -> mem1_wr=0 immediately; after release, req0 wins a tie; no replay of the aborted data.

Source files
------------

// File: rtl/crc_sched_pkg.sv
// Shared types and defaults for the CRC-protected memory write scheduler.
package crc_sched_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StCheck = 2'd2,
    StFault = 2'd3
  } state_e;

  localparam int unsigned MaxRetryDefault  = 2;
  localparam int unsigned ErrThreshDefault = 4;
  localparam int unsigned DataWidth        = 32;

  // Saturating increment for the 8-bit error counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: ties go to the requester not granted last,
// a lone valid requester always wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_valid0,
  input  logic       i_valid1,
  input  logic       i_en,
  output logic [1:0] o_gnt
);

  logic       r_last1;  // 1 when requester 1 holds the most recent grant
  logic [1:0] w_gnt;

  // One-hot grant decision, only while enabled.
  always_comb begin
    w_gnt = 2'b00;
    if (i_en) begin
      if (i_valid0 && i_valid1) begin
        w_gnt = r_last1 ? 2'b01 : 2'b10;
      end else if (i_valid0) begin
        w_gnt = 2'b01;
      end else if (i_valid1) begin
        w_gnt = 2'b10;
      end
    end
  end

  // Remember who won; reset favours requester 0 on the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last1 <= 1'b1;
    end else if (w_gnt != 2'b00) begin
      r_last1 <= w_gnt[1];
    end
  end

  assign o_gnt = w_gnt;

endmodule

// File: rtl/crc_mem_sched.sv
// Schedules writes from two requesters into a CRC-protected memory,
// rewriting on uncorrected errors and latching a sticky fault on retry
// exhaustion or when the cumulative error count reaches a threshold.
module crc_mem_sched
  import crc_sched_pkg::*;
#(
  parameter int unsigned MAX_RETRY  = MaxRetryDefault,
  parameter int unsigned ERR_THRESH = ErrThreshDefault
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  input  logic [DataWidth-1:0] req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [DataWidth-1:0] req1_data,
  output logic                 req1_ready,
  output logic                 mem1_wr,
  output logic [DataWidth-1:0] mem1_data_in,
  input  logic                 mem1_err_detected,
  input  logic                 mem1_err_corrected,
  input  logic                 fault_clr,
  output logic                 fault,
  output logic [7:0]           err_cnt
);

  localparam logic [2:0] MaxRetryW  = MAX_RETRY[2:0];
  localparam logic [7:0] ErrThreshW = ERR_THRESH[7:0];

  state_e               r_state;
  logic [2:0]           r_retry;
  logic [7:0]           r_err_cnt;
  logic [DataWidth-1:0] r_data;
  logic                 r_mem_wr;
  logic                 r_fault;

  logic [1:0]           w_gnt;
  logic                 w_arb_en;
  logic [7:0]           w_cnt_inc;
  logic                 w_thresh_hit;

  assign w_arb_en = (r_state == StIdle);

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid0 (req0_valid),
    .i_valid1 (req1_valid),
    .i_en     (w_arb_en),
    .o_gnt    (w_gnt)
  );

  // Threshold is evaluated on the post-increment count so it overrides the
  // corrected/retry outcome of the same CHECK cycle.
  always_comb begin
    w_cnt_inc    = sat_inc8(r_err_cnt);
    w_thresh_hit = mem1_err_detected && (w_cnt_inc >= ErrThreshW);
  end

  // Main FSM with registered write strobe, data and fault outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_retry   <= 3'd0;
      r_err_cnt <= 8'd0;
      r_data    <= '0;
      r_mem_wr  <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_gnt != 2'b00) begin
            r_data   <= w_gnt[0] ? req0_data : req1_data;
            r_mem_wr <= 1'b1;
            r_state  <= StWrite;
          end
        end
        StWrite: begin
          r_mem_wr <= 1'b0;
          r_state  <= StCheck;
        end
        StCheck: begin
          if (mem1_err_detected) begin
            r_err_cnt <= w_cnt_inc;
          end
          if (w_thresh_hit) begin
            r_fault <= 1'b1;
            r_state <= StFault;
          end else if (!mem1_err_detected || mem1_err_corrected) begin
            r_retry <= 3'd0;
            r_state <= StIdle;
          end else if (r_retry < MaxRetryW) begin
            // Rewrite the same latched data.
            r_retry  <= r_retry + 3'd1;
            r_mem_wr <= 1'b1;
            r_state  <= StWrite;
          end else begin
            r_fault <= 1'b1;
            r_state <= StFault;
          end
        end
        StFault: begin
          if (fault_clr) begin
            r_err_cnt <= 8'd0;
            r_retry   <= 3'd0;
            r_fault   <= 1'b0;
            r_state   <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign req0_ready   = w_gnt[0];
  assign req1_ready   = w_gnt[1];
  assign mem1_wr      = r_mem_wr;
  assign mem1_data_in = r_data;
  assign fault        = r_fault;
  assign err_cnt      = r_err_cnt;

endmodule

// File: tb/tb_crc_mem_sched.sv
// Directed and randomized checks of crc_mem_sched against a transaction-level model.
module tb_crc_mem_sched;

  localparam int MAX_RETRY  = 2;
  localparam int ERR_THRESH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_data, req1_data, mem1_data_in;
  logic        mem1_wr, mem1_err_detected, mem1_err_corrected;
  logic        fault_clr, fault;
  logic [7:0]  err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: who was granted last (1 after reset), error count, retries, fault.
  int m_last  = 1;
  int m_cnt   = 0;
  int m_retry = 0;
  bit m_fault = 0;

  always #5 clk = ~clk;

  crc_mem_sched #(
    .MAX_RETRY  (MAX_RETRY),
    .ERR_THRESH (ERR_THRESH)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .req0_valid         (req0_valid),
    .req0_data          (req0_data),
    .req0_ready         (req0_ready),
    .req1_valid         (req1_valid),
    .req1_data          (req1_data),
    .req1_ready         (req1_ready),
    .mem1_wr            (mem1_wr),
    .mem1_data_in       (mem1_data_in),
    .mem1_err_detected  (mem1_err_detected),
    .mem1_err_corrected (mem1_err_corrected),
    .fault_clr          (fault_clr),
    .fault              (fault),
    .err_cnt            (err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Assert reset mid-cycle, check the asynchronous clear, release after an edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_wr", 32'(mem1_wr), 0);
    chk("rst_data", mem1_data_in, 0);
    chk("rst_rdy", {30'd0, req1_ready, req0_ready}, 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_cnt", 32'(err_cnt), 0);
    step();
    rst_n   = 1'b1;
    m_last  = 1;
    m_cnt   = 0;
    m_retry = 0;
    m_fault = 0;
  endtask

  // One transfer starting in an IDLE cycle. mode: 0 clean, 1 corrected,
  // 2 uncorrected on every check, other = random status per check.
  task automatic xfer(input logic v0, input logic v1, input logic [31:0] d0,
                      input logic [31:0] d1, input int mode, output int w, output int nwr);
    logic [31:0] d;
    logic        det, cor;
    bit          done;
    req0_valid = v0;
    req1_valid = v1;
    req0_data  = d0;
    req1_data  = d1;
    #1;
    w = (v0 && v1) ? ((m_last == 1) ? 0 : 1) : (v0 ? 0 : 1);
    chk("ready0", 32'(req0_ready), 32'(w == 0));
    chk("ready1", 32'(req1_ready), 32'(w == 1));
    d      = (w == 0) ? d0 : d1;
    m_last = w;
    nwr    = 0;
    done   = 0;
    step();
    while (!done) begin
      chk("wr_on", 32'(mem1_wr), 1);
      chk("wr_data", mem1_data_in, d);
      chk("rdy_busy", {30'd0, req1_ready, req0_ready}, 0);
      nwr++;
      step();
      chk("wr_off", 32'(mem1_wr), 0);
      chk("hold_data", mem1_data_in, d);
      chk("rdy_chk", {30'd0, req1_ready, req0_ready}, 0);
      case (mode)
        0:       begin det = 1'b0; cor = 1'b0; end
        1:       begin det = 1'b1; cor = 1'b1; end
        2:       begin det = 1'b1; cor = 1'b0; end
        default: begin
          det = ($urandom_range(0, 3) == 0);
          cor = 1'($urandom_range(0, 1));
        end
      endcase
      mem1_err_detected  = det;
      mem1_err_corrected = cor;
      step();
      mem1_err_detected  = 1'b0;
      mem1_err_corrected = 1'b0;
      if (det) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      if (det && m_cnt >= ERR_THRESH) begin
        m_fault = 1;
        done    = 1;
      end else if (!det || cor) begin
        m_retry = 0;
        done    = 1;
      end else if (m_retry < MAX_RETRY) begin
        m_retry++;
      end else begin
        m_fault = 1;
        done    = 1;
      end
      chk("err_cnt", 32'(err_cnt), m_cnt);
      chk("fault", 32'(fault), 32'(m_fault));
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // In FAULT: requests are refused; fault_clr returns to IDLE with a clean count.
  task automatic clear_fault();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("flt_rdy", {30'd0, req1_ready, req0_ready}, 0);
      chk("flt_wr", 32'(mem1_wr), 0);
      chk("flt_on", 32'(fault), 1);
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    fault_clr  = 1'b1;
    step();
    fault_clr = 1'b0;
    chk("clr_fault", 32'(fault), 0);
    chk("clr_cnt", 32'(err_cnt), 0);
    m_cnt   = 0;
    m_retry = 0;
    m_fault = 0;
  endtask

  initial begin
    int w, nwr;
    rst_n              = 1'b1;
    req0_valid         = 1'b0;
    req1_valid         = 1'b0;
    req0_data          = '0;
    req1_data          = '0;
    mem1_err_detected  = 1'b0;
    mem1_err_corrected = 1'b0;
    fault_clr          = 1'b0;
    do_reset();

    // Contention straight after reset: req0, req1, req0, req1.
    for (int i = 0; i < 4; i++) begin
      xfer(1'b1, 1'b1, 32'hA000_0000 + i, 32'hB000_0000 + i, 0, w, nwr);
      chk("rr_order", w, i % 2);
    end

    // Single clean write.
    xfer(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0, 0, w, nwr);
    chk("single_nwr", nwr, 1);
    chk("single_cnt", 32'(err_cnt), 0);

    // Corrected error: no rewrite, count 1, next request accepted at once.
    xfer(1'b1, 1'b0, 32'h1234_5678, 32'h0, 1, w, nwr);
    chk("corr_nwr", nwr, 1);
    xfer(1'b0, 1'b1, 32'h0, 32'h8765_4321, 0, w, nwr);
    chk("corr_next", w, 1);

    // fault_clr outside FAULT has no effect.
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    chk("clr_ignored", 32'(err_cnt), 1);
    chk("clr_nofault", 32'(fault), 0);

    // Retry exhaustion from a clean count.
    do_reset();
    xfer(1'b0, 1'b1, 32'h0, 32'h5A5A_A5A5, 2, w, nwr);
    chk("retry_nwr", nwr, MAX_RETRY + 1);
    chk("retry_cnt", 32'(err_cnt), 3);
    clear_fault();

    // Threshold via corrected errors.
    for (int i = 0; i < ERR_THRESH; i++) begin
      xfer(1'b1, 1'b0, 32'hC0DE_0000 + i, 32'h0, 1, w, nwr);
    end
    chk("thresh_fault", 32'(fault), 1);
    clear_fault();

    // Reset during WRITE aborts the transfer without replay.
    req0_valid = 1'b1;
    req0_data  = 32'hCAFE_F00D;
    #1;
    chk("abort_rdy", 32'(req0_ready), 1);
    step();
    chk("abort_wr", 32'(mem1_wr), 1);
    req0_valid = 1'b0;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      chk("no_replay", 32'(mem1_wr), 0);
      step();
    end
    xfer(1'b1, 1'b1, 32'h1111_1111, 32'h2222_2222, 0, w, nwr);
    chk("post_rst_tie", w, 0);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      logic v0, v1;
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) begin
        #1;
        chk("idle_rdy", {30'd0, req1_ready, req0_ready}, 0);
        step();
        chk("idle_wr", 32'(mem1_wr), 0);
      end else begin
        xfer(v0, v1, $urandom, $urandom, 3, w, nwr);
        if (m_fault) clear_fault();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
